// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding
// and the iteration-counter width helper.
package seq_divider_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } state_e;

   function automatic int clog2(input int value);
      int bits;
      int v;
      bits = 0;
      v = value - 1;
      while (v > 0) begin
         bits = bits + 1;
         v = v >> 1;
      end
      if (bits < 1) bits = 1;
      return bits;
   endfunction

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Trial subtraction for one restoring-division step: minuend - subtrahend,
// computed as a WIDTH+1-bit ripple add of the inverted subtrahend with carry-in 1.
module trial_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sub_n;

   assign carry[0] = 1'b1;
   assign sub_n    = ~subtrahend;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_fa
         assign diff[i]      = minuend[i] ^ sub_n[i] ^ carry[i];
         assign carry[i+1]   = (minuend[i] & sub_n[i]) | (carry[i] & (minuend[i] ^ sub_n[i]));
      end
   endgenerate

   // The extended top bit is 0 + 1 + carry, so its sum bit (the borrow) is ~carry.
   assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one shift-and-trial-subtract per clock,
// start/busy/done handshake, registered results held until the next start.
//
// state | meaning
// IDLE  | waiting for start; results from the last division held
// CALC  | one quotient bit resolved per clock, WIDTH clocks total
// DONE  | done strobe for one cycle, then back to IDLE
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [2*WIDTH-1:0] shifted;
   logic [WIDTH-1:0]   r_sh;
   logic [WIDTH-1:0]   q_sh;
   logic [WIDTH-1:0]   trial_diff;
   logic               trial_borrow;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quo_step;

   // The partial remainder never needs more than WIDTH bits after the shift,
   // since it is bounded by both the divisor and the consumed dividend bits.
   assign shifted = {rem_q, quo_q} << 1;
   assign r_sh    = shifted[2*WIDTH-1:WIDTH];
   assign q_sh    = shifted[WIDTH-1:0];

   trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
      .minuend    (r_sh),
      .subtrahend (dvs_q),
      .diff       (trial_diff),
      .borrow     (trial_borrow)
   );

   assign rem_step = trial_borrow ? r_sh : trial_diff;
   assign quo_step = {q_sh[WIDTH-1:1], ~trial_borrow};

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dbz_d       = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  dbz_d       = 1'b1;
                  quotient_d  = '1;
                  remainder_d = dividend;
               end else begin
                  state_d = CALC;
                  busy_d  = 1'b1;
                  rem_d   = '0;
                  quo_d   = dividend;
                  dvs_d   = divisor;
                  cnt_d   = '0;
               end
            end
         end
         CALC: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               quotient_d  = quo_step;
               remainder_d = rem_step;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic latency model compared every
// cycle, directed cases with literal results, exhaustive and random sweeps.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: result is plain / and %, available WIDTH edges after acceptance.
   logic         m_busy, m_done, m_dbz;
   logic [W-1:0] m_q, m_r, m_pq, m_pr, m_a, m_b;
   int           m_left;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
         m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0; m_a <= '0; m_b <= '0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_q    <= m_pq;
               m_r    <= m_pr;
            end
         end else if (!m_done && start) begin
            m_a <= dividend;
            m_b <= divisor;
            if (divisor == 0) begin
               m_done <= 1'b1;
               m_dbz  <= 1'b1;
               m_q    <= '1;
               m_r    <= dividend;
            end else begin
               m_busy <= 1'b1;
               m_left <= W;
               m_pq   <= dividend / divisor;
               m_pr   <= dividend % divisor;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
         chk("quotient", 32'(quotient), 32'(m_q));
         chk("remainder", 32'(remainder), 32'(m_r));
         if (m_done && !m_dbz) begin
            chk("inv_sum", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
            chk("inv_rem_lt_dvs", 32'(remainder < m_b), 32'd1);
         end
      end
   end

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit lit,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input bit noise, input int inject_at);
      int lat = 0;
      int busy_cycles = 0;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
         if (i == inject_at) begin
            start    = 1'b1;
            dividend = 2;
            divisor  = 1;
         end
         if (busy) busy_cycles++;
         if (done) begin
            lat   = i;
            start = 1'b0;
            break;
         end
      end
      if (lat == 0) begin
         checks++;
         errors++;
         $display("FAIL timeout a=%0d b=%0d actual=no_done required=done", a, b);
      end else if (lit) begin
         chk("lit_latency", 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
         chk("lit_quotient", 32'(quotient), 32'(eq));
         chk("lit_remainder", 32'(remainder), 32'(er));
         chk("lit_dbz", 32'(div_by_zero), 32'(b == 0));
         chk("lit_busy_cycles", 32'(busy_cycles), (b == 0) ? 32'd0 : 32'(W));
      end
      @(posedge clk); #1;
      if (lit && lat != 0) begin
         chk("lit_held_q", 32'(quotient), 32'(eq));
         chk("lit_held_r", 32'(remainder), 32'(er));
         chk("lit_done_cleared", 32'(done), 32'd0);
      end
   endtask

   initial begin
      int extra;
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_div(13, 3, 1, 4, 1, 0, 0);
      run_div(15, 1, 1, 15, 0, 0, 0);
      run_div(7, 9, 1, 0, 7, 0, 0);
      run_div(9, 0, 1, 15, 9, 0, 0);
      run_div(9, 3, 1, 3, 0, 0, 0);

      run_div(12, 5, 1, 2, 2, 0, 2);
      extra = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      chk("no_second_done", 32'(extra), 32'd0);

      dividend = 14; divisor = 3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q", 32'(quotient), 32'd0);
      chk("abort_r", 32'(remainder), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      extra = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      chk("abort_no_done", 32'(extra), 32'd0);
      run_div(14, 3, 1, 4, 2, 0, 0);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_div(W'(a), W'(b), 0, '0, '0, 0, 0);
         end
      end

      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         run_div(W'($urandom), W'($urandom), 0, '0, '0, 1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
